// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Sequencer for the single shared, byte-addressed, big-endian
//               memory of the multicycle MIPS core. Arbitrates between the
//               instruction-fetch port (if_*) and the load/store port (d_*).
//               Each grant is one 32-bit word transfer with a req/ack
//               handshake and word-alignment checking.
//
//               FSM: IDLE -> ACCESS -> RESP -> IDLE
//                    IDLE -> RESP (misaligned address, no memory access)
//
// Ports       : clk, reset              clock, synchronous active-high reset
//               if_req/if_addr          fetch request and byte address
//               if_ack/if_rdata/if_err  fetch completion, word, alignment error
//               d_req/d_we/d_addr/d_wdata  load/store request
//               d_ack/d_rdata/d_err     data completion, load word, error
//               mem_addr/mem_wdata      memory address and write data
//               mem_read/mem_write      memory strobes (never both high)
//               mem_rdata               combinational memory read data
//               busy                    high in every state except IDLE
//
// Parameters  : ADDR_W      address width (default 32)
//               WAIT_CYCLES extra cycles the memory strobe is held (0..15)
//
// Config      : MEM_ARB_RR_EN  defined   -> round-robin tie-break
//                              undefined -> data port always wins a tie
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int WAIT_CYCLES = 0
) (
   input  logic              clk,
   input  logic              reset,
   // instruction fetch port
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [31:0]       if_rdata,
   output logic              if_err,
   // load/store port
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_ack,
   output logic [31:0]       d_rdata,
   output logic              d_err,
   // memory side
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [31:0]       mem_rdata,
   output logic              busy
);

   localparam logic [3:0] c_WAIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   state_t     r_state;
   logic       r_win_d;      // 1 = data port owns the current transfer
   logic       r_we;         // latched direction of the current transfer
   logic [3:0] r_wait;       // remaining extra access cycles
   logic       r_mem_write;

   logic              w_any_req;
   logic              w_pick_d;
   logic              w_sel_we;
   logic [ADDR_W-1:0] w_sel_addr;
   logic              w_misal;

`ifdef MEM_ARB_RR_EN
   // Last-winner flag: 0 = fetch won last, 1 = data won last.
   logic r_last_d;

   // On a tie the port that did not win last time gets the grant.
   assign w_pick_d = d_req & (~if_req | ~r_last_d);
`else
   // Fixed priority: data always wins a tie, fetch may starve.
   assign w_pick_d = d_req;
`endif

   assign w_any_req  = if_req | d_req;
   assign w_sel_addr = w_pick_d ? d_addr : if_addr;
   assign w_sel_we   = w_pick_d & d_we;
   assign w_misal    = |w_sel_addr[1:0];

   // The write strobe is cut combinationally by reset so that a reset landing
   // on the final access cycle of a store can never commit the write.
   assign mem_write = r_mem_write & ~reset;
   assign busy      = (r_state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_win_d     <= 1'b0;
         r_we        <= 1'b0;
         r_wait      <= 4'd0;
         r_mem_write <= 1'b0;
         mem_read    <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= 32'd0;
         if_ack      <= 1'b0;
         if_err      <= 1'b0;
         if_rdata    <= 32'd0;
         d_ack       <= 1'b0;
         d_err       <= 1'b0;
         d_rdata     <= 32'd0;
`ifdef MEM_ARB_RR_EN
         r_last_d    <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  r_win_d <= w_pick_d;
                  r_we    <= w_sel_we;
`ifdef MEM_ARB_RR_EN
                  r_last_d <= w_pick_d;
`endif
                  if (w_misal) begin
                     // Misaligned: skip the memory, answer with an error.
                     r_state <= ST_RESP;
                     if_ack  <= ~w_pick_d;
                     if_err  <= ~w_pick_d;
                     d_ack   <= w_pick_d;
                     d_err   <= w_pick_d;
                  end else begin
                     r_state     <= ST_ACCESS;
                     r_wait      <= c_WAIT;
                     mem_addr    <= w_sel_addr;
                     mem_wdata   <= w_pick_d ? d_wdata : 32'd0;
                     mem_read    <= ~w_sel_we;
                     r_mem_write <= w_sel_we;
                  end
               end
            end

            ST_ACCESS: begin
               if (r_wait == 4'd0) begin
                  r_state     <= ST_RESP;
                  mem_read    <= 1'b0;
                  r_mem_write <= 1'b0;
                  if_ack      <= ~r_win_d;
                  d_ack       <= r_win_d;
                  // Loads capture on the last strobe edge; stores leave
                  // the read registers untouched.
                  if (!r_we) begin
                     if (r_win_d) d_rdata  <= mem_rdata;
                     else         if_rdata <= mem_rdata;
                  end
               end else begin
                  r_wait <= r_wait - 4'd1;
               end
            end

            ST_RESP: begin
               // Requests are deliberately ignored here; the still-high req
               // of the port being acked must not re-trigger a grant.
               r_state <= ST_IDLE;
               if_ack  <= 1'b0;
               if_err  <= 1'b0;
               d_ack   <= 1'b0;
               d_err   <= 1'b0;
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter. Two
//               instances: WAIT_CYCLES=0 (main) and WAIT_CYCLES=3 (slow
//               memory). Each has a 512-byte big-endian memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

   logic clk;
   logic reset;
   logic init;

   // instance 0 (WAIT_CYCLES = 0)
   logic        if_req0, if_ack0, if_err0, d_req0, d_we0, d_ack0, d_err0;
   logic [31:0] if_addr0, d_addr0, d_wdata0, if_rdata0, d_rdata0;
   logic [31:0] mem_addr0, mem_wdata0, mem_rdata0;
   logic        mem_read0, mem_write0, busy0;

   // instance 3 (WAIT_CYCLES = 3)
   logic        if_req3, if_ack3, if_err3, d_req3, d_we3, d_ack3, d_err3;
   logic [31:0] if_addr3, d_addr3, d_wdata3, if_rdata3, d_rdata3;
   logic [31:0] mem_addr3, mem_wdata3, mem_rdata3;
   logic        mem_read3, mem_write3, busy3;

   logic [7:0] m0 [0:511];
   logic [7:0] m3 [0:511];
   logic [8:0] a0, a3;

   int n_chk;
   int n_fail;
   int wr_cnt0;
   int rd_cnt3;
   int both_cnt;
   int oob_cnt;

   mem_port_arbiter #(.ADDR_W(32), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .reset(reset),
      .if_req(if_req0), .if_addr(if_addr0), .if_ack(if_ack0),
      .if_rdata(if_rdata0), .if_err(if_err0),
      .d_req(d_req0), .d_we(d_we0), .d_addr(d_addr0), .d_wdata(d_wdata0),
      .d_ack(d_ack0), .d_rdata(d_rdata0), .d_err(d_err0),
      .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_read(mem_read0),
      .mem_write(mem_write0), .mem_rdata(mem_rdata0), .busy(busy0)
   );

   mem_port_arbiter #(.ADDR_W(32), .WAIT_CYCLES(3)) u_dut3 (
      .clk(clk), .reset(reset),
      .if_req(if_req3), .if_addr(if_addr3), .if_ack(if_ack3),
      .if_rdata(if_rdata3), .if_err(if_err3),
      .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
      .d_ack(d_ack3), .d_rdata(d_rdata3), .d_err(d_err3),
      .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_read(mem_read3),
      .mem_write(mem_write3), .mem_rdata(mem_rdata3), .busy(busy3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Big-endian memories: byte at the word address is the MSB.
   assign a0 = mem_addr0[8:0];
   assign a3 = mem_addr3[8:0];
   assign mem_rdata0 = {m0[a0], m0[a0 + 9'd1], m0[a0 + 9'd2], m0[a0 + 9'd3]};
   assign mem_rdata3 = {m3[a3], m3[a3 + 9'd1], m3[a3 + 9'd2], m3[a3 + 9'd3]};

   always @(posedge clk) begin
      if (init) begin
         for (int i = 0; i < 512; i++) begin
            m0[i] <= 8'h00;
            m3[i] <= 8'h00;
         end
         m0[0] <= 8'h00; m0[1] <= 8'h43; m0[2] <= 8'h08; m0[3] <= 8'h22;
         m3[0] <= 8'h00; m3[1] <= 8'h43; m3[2] <= 8'h08; m3[3] <= 8'h22;
      end else begin
         if (mem_write0) begin
            m0[a0]         <= mem_wdata0[31:24];
            m0[a0 + 9'd1]  <= mem_wdata0[23:16];
            m0[a0 + 9'd2]  <= mem_wdata0[15:8];
            m0[a0 + 9'd3]  <= mem_wdata0[7:0];
         end
         if (mem_write3) begin
            m3[a3]         <= mem_wdata3[31:24];
            m3[a3 + 9'd1]  <= mem_wdata3[23:16];
            m3[a3 + 9'd2]  <= mem_wdata3[15:8];
            m3[a3 + 9'd3]  <= mem_wdata3[7:0];
         end
      end
   end

   // Activity monitors.
   always @(posedge clk) begin
      if (mem_write0)                       wr_cnt0  <= wr_cnt0 + 1;
      if (mem_read3)                        rd_cnt3  <= rd_cnt3 + 1;
      if ((mem_read0 && mem_write0) || (mem_read3 && mem_write3))
                                            both_cnt <= both_cnt + 1;
      if (((mem_read0 || mem_write0) && mem_addr0[31:9] != 23'd0) ||
          ((mem_read3 || mem_write3) && mem_addr3[31:9] != 23'd0))
                                            oob_cnt  <= oob_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one request on instance 0 and wait for its ack; returns the number
   // of clock edges from the sampling edge to ack (ack cycle is left current).
   task automatic req0(input logic is_d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, output int lat);
      lat = 0;
      if (is_d) begin
         d_req0 = 1'b1; d_we0 = we; d_addr0 = addr; d_wdata0 = wdata;
      end else begin
         if_req0 = 1'b1; if_addr0 = addr;
      end
      for (int k = 0; k < 20; k++) begin
         step();
         lat++;
         if (is_d ? d_ack0 : if_ack0) break;
      end
      d_req0  = 1'b0;
      if_req0 = 1'b0;
   endtask

   logic ord [0:3];     // 1 = data ack, 0 = fetch ack
   logic exp_ord [0:3];
   int   got;
   int   lat;
   int   wc;

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      n_chk = 0; n_fail = 0;
      wr_cnt0 = 0; rd_cnt3 = 0; both_cnt = 0; oob_cnt = 0;
      reset = 1'b1; init = 1'b1;
      if_req0 = 0; if_addr0 = 0; d_req0 = 0; d_we0 = 0; d_addr0 = 0; d_wdata0 = 0;
      if_req3 = 0; if_addr3 = 0; d_req3 = 0; d_we3 = 0; d_addr3 = 0; d_wdata3 = 0;
      step(); step(); step();
      init = 1'b0;

      // Reset state
      chk("rst_busy",   {31'd0, busy0},      32'd0);
      chk("rst_acks",   {30'd0, if_ack0, d_ack0}, 32'd0);
      chk("rst_errs",   {30'd0, if_err0, d_err0}, 32'd0);
      chk("rst_strobe", {30'd0, mem_read0, mem_write0}, 32'd0);
      chk("rst_maddr",  mem_addr0,  32'd0);
      chk("rst_mwdata", mem_wdata0, 32'd0);
      chk("rst_ifrd",   if_rdata0,  32'd0);
      chk("rst_drd",    d_rdata0,   32'd0);
      reset = 1'b0;
      step();

      // Aligned fetch from 0x0
      req0(1'b0, 1'b0, 32'h0, 32'h0, lat);
      chk("f_lat",  lat, 32'd2);
      chk("f_ack",  {31'd0, if_ack0}, 32'd1);
      chk("f_data", if_rdata0, 32'h00430822);
      chk("f_err",  {31'd0, if_err0}, 32'd0);
      step();
      chk("f_idle", {31'd0, busy0}, 32'd0);

      // Store 0xDEADBEEF to 0x100
      req0(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, lat);
      chk("st_lat", lat, 32'd2);
      chk("st_err", {31'd0, d_err0}, 32'd0);
      chk("st_drd", d_rdata0, 32'd0);
      step();
      chk("st_byte0", {24'd0, m0[256]}, 32'hDE);
      chk("st_byte3", {24'd0, m0[259]}, 32'hEF);

      // Load back 0x100
      req0(1'b1, 1'b0, 32'h100, 32'h0, lat);
      chk("ld_lat",    lat, 32'd2);
      chk("ld_data",   d_rdata0, 32'hDEADBEEF);
      chk("ld_ifhold", if_rdata0, 32'h00430822);
      step();

      // Misaligned store to 0x102: error, no write
      wc = wr_cnt0;
      req0(1'b1, 1'b1, 32'h102, 32'h12345678, lat);
      chk("mis_lat", lat, 32'd1);
      chk("mis_err", {31'd0, d_err0}, 32'd1);
      step();
      chk("mis_nowr", wr_cnt0, wc);
      chk("mis_mem",  {m0[256], m0[257], m0[258], m0[259]}, 32'hDEADBEEF);

      // Misaligned fetch from 0x1
      req0(1'b0, 1'b0, 32'h1, 32'h0, lat);
      chk("fmis_lat",  lat, 32'd1);
      chk("fmis_err",  {31'd0, if_err0}, 32'd1);
      chk("fmis_hold", if_rdata0, 32'h00430822);
      step();

      // Reset on the final access cycle of a store
      wc = wr_cnt0;
      d_req0 = 1'b1; d_we0 = 1'b1; d_addr0 = 32'h104; d_wdata0 = 32'hCAFEF00D;
      step();
      chk("ra_busy",  {31'd0, busy0}, 32'd1);
      chk("ra_wr_on", {31'd0, mem_write0}, 32'd1);
      d_req0 = 1'b0;
      reset  = 1'b1;
      #1;
      chk("ra_gate", {31'd0, mem_write0}, 32'd0);
      step();
      reset = 1'b0;
      chk("ra_idle", {31'd0, busy0}, 32'd0);
      chk("ra_noack", {31'd0, d_ack0}, 32'd0);
      chk("ra_nowr", wr_cnt0, wc);
      chk("ra_mem", {m0[260], m0[261], m0[262], m0[263]}, 32'h0);
      step();

      // Both requesters held for 4 grants (last-winner flag fresh from reset)
`ifdef MEM_ARB_RR_EN
      exp_ord[0] = 1'b1; exp_ord[1] = 1'b0; exp_ord[2] = 1'b1; exp_ord[3] = 1'b0;
`else
      exp_ord[0] = 1'b1; exp_ord[1] = 1'b1; exp_ord[2] = 1'b1; exp_ord[3] = 1'b1;
`endif
      for (int i = 0; i < 4; i++) ord[i] = 1'bx;
      got = 0;
      if_req0 = 1'b1; if_addr0 = 32'h0;
      d_req0  = 1'b1; d_we0 = 1'b0; d_addr0 = 32'h100;
      for (int k = 0; k < 40 && got < 4; k++) begin
         step();
         if (d_ack0)  begin ord[got] = 1'b1; got++; end
         else if (if_ack0) begin ord[got] = 1'b0; got++; end
      end
      if_req0 = 1'b0; d_req0 = 1'b0;
      chk("arb_cnt", got, 32'd4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("arb_ord%0d", i), {31'd0, ord[i]}, {31'd0, exp_ord[i]});
      step(); step();

      // WAIT_CYCLES=3 load from 0x0
      d_req3 = 1'b1; d_we3 = 1'b0; d_addr3 = 32'h0;
      lat = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         lat++;
         if (d_ack3) break;
      end
      d_req3 = 1'b0;
      chk("w3_lat",  lat, 32'd5);
      chk("w3_data", d_rdata3, 32'h00430822);
      chk("w3_rdcy", rd_cnt3, 32'd4);
      step();

      chk("rw_excl", both_cnt, 32'd0);
      chk("addr_rng", oob_cnt, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
